median_stream_3x3: RTL and testbench

MEDIAN_STREAM_3X3 -- requirements
Module: median_stream_3x3

---
 rtl/median_stream_3x3_if.sv | 36 +++
 rtl/median_stream_3x3.sv | 187 ++++++++++++++++++
 tb/tb_median_stream_3x3.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/median_stream_3x3_if.sv
// Stream bundle for median_stream_3x3.
//   in_valid/in_ready/in_sol/in_eol : input word handshake and line flags
//   row_top/row_mid/row_bot         : same word position of three adjacent lines,
//                                     pixel 0 in the MSBs
//   out_valid/out_ready             : result handshake
//   out_data/out_sol/out_eol        : medians of row_mid pixels plus line flags
// master drives the input stream and consumes results; slave is the filter.
interface median_stream_3x3_if #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int PIXELS_PER_WORD = 4
);
    localparam int WORD_WIDTH = PIXEL_WIDTH * PIXELS_PER_WORD;

    logic                  in_valid;
    logic                  in_ready;
    logic                  in_sol;
    logic                  in_eol;
    logic [WORD_WIDTH-1:0] row_top;
    logic [WORD_WIDTH-1:0] row_mid;
    logic [WORD_WIDTH-1:0] row_bot;
    logic                  out_valid;
    logic                  out_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_sol;
    logic                  out_eol;

    modport master (
        output in_valid, in_sol, in_eol, row_top, row_mid, row_bot, out_ready,
        input  in_ready, out_valid, out_data, out_sol, out_eol
    );

    modport slave (
        input  in_valid, in_sol, in_eol, row_top, row_mid, row_bot, out_ready,
        output in_ready, out_valid, out_data, out_sol, out_eol
    );
endinterface

// File: rtl/median_stream_3x3.sv
// 3x3 median filter over a word-packed three-line pixel stream.
//   clk       : single clock, rising edge
//   rst_n     : synchronous active-low reset
//   bus       : median_stream_3x3_if.slave (input words in, median words out)
//   err_proto : sticky flag, set by a beat without in_sol while idle or a
//               beat with in_sol in the middle of a line
// One word is held until its right neighbour column is known (next word of the
// line, or the right border once the held word carries in_eol). The median
// network sits between the held columns and the output register.

// Exact median of a 3x3 window: sort each column, then the median of
// {max of lows, median of mids, min of highs} is the 5th smallest of all nine.
module median9_lane #(
    parameter int PW = 8
) (
    input  logic [8:0][PW-1:0] win,   // [2:0] left col, [5:3] centre, [8:6] right (top,mid,bot)
    output logic [PW-1:0]      med
);
    function automatic logic [PW-1:0] mn(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PW-1:0] mx(input logic [PW-1:0] a, input logic [PW-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [PW-1:0] md3(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                          input logic [PW-1:0] c);
        return mx(mn(a, b), mn(mx(a, b), c));
    endfunction

    logic [2:0][PW-1:0] lo, mi, hi;

    always_comb begin
        lo = '0;
        mi = '0;
        hi = '0;
        for (int k = 0; k < 3; k++) begin
            lo[k] = mn(mn(win[3*k], win[3*k+1]), win[3*k+2]);
            hi[k] = mx(mx(win[3*k], win[3*k+1]), win[3*k+2]);
            mi[k] = md3(win[3*k], win[3*k+1], win[3*k+2]);
        end
    end

    assign med = md3(mx(mx(lo[0], lo[1]), lo[2]),
                     md3(mi[0], mi[1], mi[2]),
                     mn(mn(hi[0], hi[1]), hi[2]));
endmodule

module median_stream_3x3 #(
    parameter int PIXEL_WIDTH     = 8,
    parameter int PIXELS_PER_WORD = 4,
    parameter int BORDER_MODE     = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    median_stream_3x3_if.slave    bus,
    output logic                  err_proto
);
    localparam int PW  = PIXEL_WIDTH;
    localparam int PPW = PIXELS_PER_WORD;
    localparam int WW  = PW * PPW;

    typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_t;

    state_t                state, state_d;
    logic [WW-1:0]         top_q, mid_q, bot_q;
    logic [2:0][PW-1:0]    prev_col;      // last column of the previous word
    logic                  held_sol;      // held word opens its line
    logic                  out_valid_q, out_sol_q, out_eol_q, err_q;
    logic [WW-1:0]         out_data_q;

    logic                  in_rdy, out_free, load_out, store_in, err_set;
    logic [PPW+1:0][2:0][PW-1:0] cols;   // left neighbour, held pixels, right neighbour
    logic [WW-1:0]         med_word;

    assign out_free = !out_valid_q || bus.out_ready;

    // Column assembly: each column is {bot, mid, top} indexed [2:0].
    always_comb begin
        cols = '0;
        for (int i = 0; i < PPW; i++) begin
            cols[i+1][0] = top_q[(PPW-1-i)*PW +: PW];
            cols[i+1][1] = mid_q[(PPW-1-i)*PW +: PW];
            cols[i+1][2] = bot_q[(PPW-1-i)*PW +: PW];
        end
        if (!held_sol)
            cols[0] = prev_col;
        else if (BORDER_MODE == 0)
            cols[0] = cols[1];
        // right neighbour: column 0 of the incoming word, or the border while flushing
        if (state != FLUSH) begin
            cols[PPW+1][0] = bus.row_top[WW-1 -: PW];
            cols[PPW+1][1] = bus.row_mid[WW-1 -: PW];
            cols[PPW+1][2] = bus.row_bot[WW-1 -: PW];
        end else if (BORDER_MODE == 0) begin
            cols[PPW+1] = cols[PPW];
        end
    end

    for (genvar g = 0; g < PPW; g++) begin : g_lane
        median9_lane #(.PW(PW)) u_lane (
            .win ({cols[g+2], cols[g+1], cols[g]}),
            .med (med_word[(PPW-1-g)*PW +: PW])
        );
    end

    always_comb begin
        state_d  = state;
        in_rdy   = 1'b0;
        load_out = 1'b0;
        store_in = 1'b0;
        err_set  = 1'b0;
        case (state)
            IDLE: begin
                in_rdy = 1'b1;
                if (bus.in_valid) begin
                    if (bus.in_sol) begin
                        store_in = 1'b1;
                        state_d  = bus.in_eol ? FLUSH : HOLD;
                    end else begin
                        err_set = 1'b1;   // orphan beat is dropped
                    end
                end
            end
            HOLD: begin
                in_rdy = out_free;
                if (bus.in_valid && out_free) begin
                    load_out = 1'b1;
                    store_in = 1'b1;
                    err_set  = bus.in_sol;   // treated as a continuation beat
                    state_d  = bus.in_eol ? FLUSH : HOLD;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load_out = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            top_q       <= '0;
            mid_q       <= '0;
            bot_q       <= '0;
            prev_col    <= '0;
            held_sol    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sol_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state <= state_d;
            if (err_set)
                err_q <= 1'b1;
            if (store_in) begin
                top_q    <= bus.row_top;
                mid_q    <= bus.row_mid;
                bot_q    <= bus.row_bot;
                prev_col <= cols[PPW];
                held_sol <= (state == IDLE);   // only line openers are stored from IDLE
            end
            if (load_out) begin
                out_data_q <= med_word;
                out_sol_q  <= held_sol;
                out_eol_q  <= (state == FLUSH);
            end
            if (load_out)
                out_valid_q <= 1'b1;
            else if (bus.out_ready)
                out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sol   = out_sol_q;
    assign bus.out_eol   = out_eol_q;
    assign err_proto     = err_q;
endmodule

// File: tb/tb_median_stream_3x3.sv
// Bench for median_stream_3x3: two instances (replicate and zero border) share
// one stimulus stream; expectations come from a direct 9-value sort per pixel.
module tb_median_stream_3x3;
    localparam int PW   = 8;
    localparam int PPW  = 4;
    localparam int WW   = PW * PPW;
    localparam int MAXC = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    median_stream_3x3_if #(.PIXEL_WIDTH(PW), .PIXELS_PER_WORD(PPW)) b0 ();
    median_stream_3x3_if #(.PIXEL_WIDTH(PW), .PIXELS_PER_WORD(PPW)) b1 ();
    logic err0, err1;

    median_stream_3x3 #(.PIXEL_WIDTH(PW), .PIXELS_PER_WORD(PPW), .BORDER_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .err_proto(err0));
    median_stream_3x3 #(.PIXEL_WIDTH(PW), .PIXELS_PER_WORD(PPW), .BORDER_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .err_proto(err1));

    assign b1.in_valid  = b0.in_valid;
    assign b1.in_sol    = b0.in_sol;
    assign b1.in_eol    = b0.in_eol;
    assign b1.row_top   = b0.row_top;
    assign b1.row_mid   = b0.row_mid;
    assign b1.row_bot   = b0.row_bot;
    assign b1.out_ready = b0.out_ready;

    int errors = 0;
    int checks = 0;
    logic [WW+1:0] exp0[$], exp1[$];      // {sol, eol, data}
    logic [PW-1:0] pix[3][MAXC];          // current line: rows top/mid/bot
    int   bp_mode = 0;                    // 0 ready, 1 random, 2 stalled
    bit   acc, stall_pend, flush_pend;
    logic [WW+1:0] stall_word;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int med9(input int v[9]);
        int a[9];
        int t;
        a = v;
        for (int i = 0; i < 9; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
        return a[4];
    endfunction

    function automatic int nb(input int r, input int c, input int ncol, input int mode);
        if (c < 0)     return (mode != 0) ? 0 : int'(pix[r][0]);
        if (c >= ncol) return (mode != 0) ? 0 : int'(pix[r][ncol-1]);
        return int'(pix[r][c]);
    endfunction

    function automatic logic [WW-1:0] pack(input int r, input int w);
        logic [WW-1:0] x;
        x = '0;
        for (int i = 0; i < PPW; i++) x[(PPW-1-i)*PW +: PW] = pix[r][w*PPW+i];
        return x;
    endfunction

    task automatic gen_expect(input int nw);
        int v0[9], v1[9];
        logic [WW-1:0] w0, w1;
        for (int w = 0; w < nw; w++) begin
            w0 = '0;
            w1 = '0;
            for (int i = 0; i < PPW; i++) begin
                int c;
                int k;
                c = w * PPW + i;
                k = 0;
                for (int r = 0; r < 3; r++)
                    for (int d = -1; d <= 1; d++) begin
                        v0[k] = nb(r, c + d, nw * PPW, 0);
                        v1[k] = nb(r, c + d, nw * PPW, 1);
                        k++;
                    end
                w0[(PPW-1-i)*PW +: PW] = PW'(med9(v0));
                w1[(PPW-1-i)*PW +: PW] = PW'(med9(v1));
            end
            exp0.push_back({w == 0, w == nw - 1, w0});
            exp1.push_back({w == 0, w == nw - 1, w1});
        end
    endtask

    task automatic fill_random(input int nw);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < nw * PPW; c++) pix[r][c] = PW'($urandom);
    endtask

    // Called at a negedge; samples #1 later, then advances one full clock.
    task automatic tick();
        logic [WW+1:0] g0, g1;
        case (bp_mode)
            0:       b0.out_ready = 1'b1;
            1:       b0.out_ready = ($urandom_range(0, 2) != 0);
            default: b0.out_ready = 1'b0;
        endcase
        #1;
        g0 = {b0.out_sol, b0.out_eol, b0.out_data};
        g1 = {b1.out_sol, b1.out_eol, b1.out_data};
        if (stall_pend) begin
            chk("stall_vld", 64'(b0.out_valid), 64'(1));
            chk("stall_dat", 64'(g0), 64'(stall_word));
        end
        if (flush_pend) chk("flush_rdy", 64'(b0.in_ready), 64'(0));
        stall_pend = 0;
        flush_pend = 0;
        if (b0.out_valid && b0.out_ready) begin
            if (exp0.size() == 0) chk("extra0", 64'(1), 64'(0));
            else chk("out0", 64'(g0), 64'(exp0.pop_front()));
        end
        if (b1.out_valid && b1.out_ready) begin
            if (exp1.size() == 0) chk("extra1", 64'(1), 64'(0));
            else chk("out1", 64'(g1), 64'(exp1.pop_front()));
        end
        if (b0.out_valid && !b0.out_ready) begin
            stall_pend = 1;
            stall_word = g0;
        end
        acc = b0.in_valid && b0.in_ready;
        if (acc && b0.in_eol) flush_pend = 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_line(input int nw, input int nsend, input bit midsol, input bit gaps);
        for (int w = 0; w < nsend; w++) begin
            int t;
            t = 0;
            if (gaps)
                while ($urandom_range(0, 3) == 0) begin b0.in_valid = 1'b0; tick(); end
            b0.in_valid = 1'b1;
            b0.in_sol   = (w == 0) || (midsol && w == 1);
            b0.in_eol   = (w == nw - 1);
            b0.row_top  = pack(0, w);
            b0.row_mid  = pack(1, w);
            b0.row_bot  = pack(2, w);
            do begin tick(); t++; end while (!acc && t < 500);
            if (!acc) chk("accept_timeout", 64'(0), 64'(1));
        end
        b0.in_valid = 1'b0;
        b0.in_sol   = 1'b0;
        b0.in_eol   = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        bp_mode = 0;
        while ((exp0.size() != 0 || exp1.size() != 0) && t < 300) begin tick(); t++; end
        for (int i = 0; i < 3; i++) tick();   // any extra word would be flagged here
        chk("drain0", 64'(exp0.size()), 64'(0));
        chk("drain1", 64'(exp1.size()), 64'(0));
    endtask

    initial begin
        b0.in_valid = 1'b0; b0.in_sol = 1'b0; b0.in_eol = 1'b0;
        b0.row_top = '0; b0.row_mid = '0; b0.row_bot = '0; b0.out_ready = 1'b1;
        stall_pend = 0; flush_pend = 0; acc = 0; stall_word = '0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_vld",  64'(b0.out_valid), 64'(0));
        chk("rst_data", 64'(b0.out_data),  64'(0));
        chk("rst_flag", 64'({b0.out_sol, b0.out_eol}), 64'(0));
        chk("rst_err",  64'(err0), 64'(0));
        chk("rst_rdy",  64'(b0.in_ready), 64'(1));

        // single-word line, both border modes
        pix[0][0] = 8'h01; pix[0][1] = 8'h02; pix[0][2] = 8'h03; pix[0][3] = 8'h04;
        pix[1][0] = 8'h05; pix[1][1] = 8'h06; pix[1][2] = 8'h07; pix[1][3] = 8'h08;
        pix[2][0] = 8'h09; pix[2][1] = 8'h0A; pix[2][2] = 8'h0B; pix[2][3] = 8'h0C;
        exp0.push_back({1'b1, 1'b1, 32'h05060708});
        exp1.push_back({1'b1, 1'b1, 32'h02060704});
        send_line(1, 1, 0, 0);
        chk("lat_flush", 64'(b0.out_valid), 64'(0));
        tick();
        chk("lat_load", 64'(b0.out_valid), 64'(1));
        drain();

        // impulse straddling a word boundary
        for (int r = 0; r < 3; r++) for (int c = 0; c < 12; c++) pix[r][c] = 8'h80;
        pix[1][7] = 8'hFF;
        exp0.push_back({1'b1, 1'b0, 32'h80808080});
        exp0.push_back({1'b0, 1'b0, 32'h80808080});
        exp0.push_back({1'b0, 1'b1, 32'h80808080});
        exp1.push_back({1'b1, 1'b0, 32'h80808080});
        exp1.push_back({1'b0, 1'b0, 32'h80808080});
        exp1.push_back({1'b0, 1'b1, 32'h80808080});
        send_line(3, 3, 0, 0);
        drain();

        // random lines under random backpressure
        bp_mode = 1;
        for (int n = 0; n < 100; n++) begin
            int nw;
            nw = $urandom_range(1, 4);
            fill_random(nw);
            gen_expect(nw);
            send_line(nw, nw, 0, 1);
        end
        drain();
        chk("err_clean", 64'(err0), 64'(0));

        // orphan beat while idle, then a good line
        b0.in_valid = 1'b1; b0.in_sol = 1'b0; b0.in_eol = 1'b0;
        b0.row_mid = 32'hDEADBEEF;
        tick();
        b0.in_valid = 1'b0;
        tick();
        chk("err_orphan", 64'({err0, err1}), 64'(3));
        bp_mode = 1;
        fill_random(3);
        gen_expect(3);
        send_line(3, 3, 0, 1);
        drain();
        chk("err_sticky", 64'(err0), 64'(1));

        // reset while a word is held and the output is stalled
        bp_mode = 2;
        fill_random(3);
        send_line(3, 2, 0, 0);
        chk("pre_rst_vld", 64'(b0.out_valid), 64'(1));
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        stall_pend = 0;
        chk("mid_rst_vld", 64'(b0.out_valid), 64'(0));
        chk("mid_rst_err", 64'(err0), 64'(0));
        chk("mid_rst_rdy", 64'(b0.in_ready), 64'(1));

        // in_sol on a continuation beat: flagged, filtered as normal
        bp_mode = 1;
        fill_random(3);
        gen_expect(3);
        send_line(3, 3, 1, 1);
        drain();
        chk("err_midsol", 64'({err0, err1}), 64'(3));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
